// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive path: control tokens, token lookup
// and the symbol-alignment state encoding.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    VERIFY,
    LOCKED
  } align_state_t;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] code;
  } ctrl_match_t;

  // Exact match only; a symbol one bit off alignment never looks like a token.
  function automatic ctrl_match_t ctrl_lookup(input logic [9:0] sym);
    ctrl_match_t m;
    m.is_ctrl = 1'b1;
    m.code    = 2'b00;
    case (sym)
      CTRL_TOKEN_00: m.code = 2'b00;
      CTRL_TOKEN_01: m.code = 2'b01;
      CTRL_TOKEN_10: m.code = 2'b10;
      CTRL_TOKEN_11: m.code = 2'b11;
      default:       m.is_ctrl = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b TMDS symbol decode: control-token detect plus the
// inverse of the transition-minimising data encoding.
import tmds_pkg::*;

module tmds_symbol_decode (
  input  logic [9:0] sym,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  ctrl_match_t match;
  logic [7:0]  d;

  always_comb begin
    match   = ctrl_lookup(sym);
    is_ctrl = match.is_ctrl;
    ctrl    = match.code;
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decode.sv
// One TMDS receive channel: two-stage decode pipeline plus the word-alignment
// FSM that drives the deserializer bitslip and reports lock.
//
//   state  | meaning
//   SEARCH | looking for any control token; misses counted toward a bitslip
//   SLIP   | bitslip issued, waiting for the deserializer to settle
//   VERIFY | counting a run of consecutive control tokens
//   LOCKED | aligned; long absence of blanking drops back to SEARCH
import tmds_pkg::*;

module tmds_decode #(
  parameter int LOCK_COUNT     = 16,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       valid_out,
  output logic       locked_out,
  output logic       bitslip_out
);

  localparam int CNT_MAX_A = (SEARCH_TIMEOUT > LOCK_COUNT) ? SEARCH_TIMEOUT : LOCK_COUNT;
  localparam int CNT_MAX   = (CNT_MAX_A > SLIP_WAIT) ? CNT_MAX_A : SLIP_WAIT;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MISS_LAST = CW'(SEARCH_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0] SLIP_LAST = CW'(SLIP_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  logic       sym_is_ctrl;
  logic [1:0] sym_ctrl;
  logic [7:0] sym_data;

  tmds_symbol_decode u_symbol_decode (
    .sym     (tmds_in),
    .is_ctrl (sym_is_ctrl),
    .ctrl    (sym_ctrl),
    .data    (sym_data)
  );

  align_state_t  state_q, state_d;
  logic [CW-1:0] miss_q, miss_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] slip_q, slip_d;
  logic          bitslip_d;

  logic          v1;
  logic          is_ctrl1;
  logic [1:0]    ctrl1;
  logic [7:0]    data1;
  logic          lock1;

  always_comb begin
    state_d   = state_q;
    miss_d    = miss_q;
    run_d     = run_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (valid_in) begin
          if (sym_is_ctrl) begin
            state_d = (LOCK_LAST == '0) ? LOCKED : VERIFY;
            run_d   = CNT_ONE;
          end else if (miss_q == MISS_LAST) begin
            state_d   = SLIP;
            bitslip_d = 1'b1;
            slip_d    = '0;
          end else begin
            miss_d = sat_inc(miss_q);
          end
        end
      end
      SLIP: begin
        if (slip_q == SLIP_LAST) begin
          state_d = SEARCH;
          miss_d  = '0;
          run_d   = '0;
          slip_d  = '0;
        end else begin
          slip_d = sat_inc(slip_q);
        end
      end
      VERIFY: begin
        if (valid_in) begin
          if (sym_is_ctrl) begin
            if (run_q == LOCK_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
            end else begin
              run_d = sat_inc(run_q);
            end
          end else begin
            // Miss count survives so false token matches cannot stall slipping forever.
            state_d = SEARCH;
            run_d   = '0;
            miss_d  = sat_inc(miss_q);
          end
        end
      end
      LOCKED: begin
        if (valid_in) begin
          if (sym_is_ctrl) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            state_d = SEARCH;
            miss_d  = '0;
            run_d   = '0;
          end else begin
            miss_d = sat_inc(miss_q);
          end
        end
      end
      default: begin
        state_d = SEARCH;
        miss_d  = '0;
        run_d   = '0;
        slip_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= SEARCH;
      miss_q      <= '0;
      run_q       <= '0;
      slip_q      <= '0;
      bitslip_out <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_q      <= miss_d;
      run_q       <= run_d;
      slip_q      <= slip_d;
      bitslip_out <= bitslip_d;
    end
  end

  assign locked_out = (state_q == LOCKED);

  // Lock is sampled with the symbol so de_out reflects the state it arrived in.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      v1       <= 1'b0;
      is_ctrl1 <= 1'b0;
      ctrl1    <= '0;
      data1    <= '0;
      lock1    <= 1'b0;
    end else begin
      v1       <= valid_in;
      is_ctrl1 <= sym_is_ctrl;
      ctrl1    <= sym_ctrl;
      data1    <= sym_data;
      lock1    <= (state_q == LOCKED);
    end
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      data_out  <= '0;
      ctrl_out  <= '0;
      de_out    <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= v1;
      de_out    <= v1 & ~is_ctrl1 & lock1;
      if (v1) begin
        if (is_ctrl1) begin
          ctrl_out <= ctrl1;
          data_out <= '0;
        end else begin
          data_out <= data1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmds_decode.sv
// Scoreboard bench for tmds_decode: directed symbols with hand-decoded
// expectations, plus alignment, lock-loss and reset scenarios.
`timescale 1ns/1ps

module tb_tmds_decode;

  logic       clk_pixel_in = 1'b0;
  logic       rst_in       = 1'b1;
  logic [9:0] tmds_in      = '0;
  logic       valid_in     = 1'b0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       valid_out;
  logic       locked_out;
  logic       bitslip_out;

  tmds_decode dut (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .tmds_in      (tmds_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .ctrl_out     (ctrl_out),
    .de_out       (de_out),
    .valid_out    (valid_out),
    .locked_out   (locked_out),
    .bitslip_out  (bitslip_out)
  );

  always #5 clk_pixel_in = ~clk_pixel_in;

  typedef struct {
    logic       chk;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    int         stamp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_slip = 0;
  int   last_slip = -1;

  always @(posedge clk_pixel_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_pixel_in) begin
    if (!rst_in && valid_out) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid_out", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("latency", cyc - mon_e.stamp, 2);
        if (mon_e.chk) begin
          check("data_out", data_out, mon_e.data);
          check("ctrl_out", ctrl_out, mon_e.ctrl);
          check("de_out", de_out, mon_e.de);
        end
      end
    end
    if (!rst_in && bitslip_out) begin
      if (last_slip >= 0) check("bitslip_spacing_ok", (cyc - last_slip) >= 17, 1);
      last_slip = cyc;
      n_slip++;
    end
  end

  task automatic send(input logic [9:0] sym, input logic chk, input logic [7:0] d,
                      input logic [1:0] c, input logic de);
    exp_t e;
    tmds_in  = sym;
    valid_in = 1'b1;
    e.chk    = chk;
    e.data   = d;
    e.ctrl   = c;
    e.de     = de;
    e.stamp  = cyc;
    sbq.push_back(e);
    @(posedge clk_pixel_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk_pixel_in);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_ctrl_out"}, ctrl_out, 0);
    check({tag, "_de_out"}, de_out, 0);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_locked_out"}, locked_out, 0);
    check({tag, "_bitslip_out"}, bitslip_out, 0);
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] dd;
    dd = {w, w} >> k;
    return dd[9:0];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int slips_before;
    int off, n, first_slip, second_slip, lock_n;

    repeat (3) @(posedge clk_pixel_in);
    #1;
    check_all_zero("reset");
    rst_in = 1'b0;
    idle(2);

    // Not locked: de_out stays 0, ctrl_out holds the last code on data.
    send(10'h1FF, 1, 8'h01, 2'b00, 0);
    send(10'h0AB, 1, 8'h00, 2'b01, 0);
    send(10'h1FF, 1, 8'h01, 2'b01, 0);
    idle(1);
    send(10'h100, 1, 8'h00, 2'b01, 0);
    idle(3);

    for (int i = 0; i < 16; i++) begin
      send(10'h354, 1, 8'h00, 2'b00, 0);
      if (i == 14) check("locked_before_16th", locked_out, 0);
    end
    check("locked_after_16th", locked_out, 1);

    send(10'h1FF, 1, 8'h01, 2'b00, 1);
    send(10'h100, 1, 8'h00, 2'b00, 1);
    idle(2);
    send(10'h2FF, 1, 8'hFE, 2'b00, 1);
    send(10'h10F, 1, 8'h11, 2'b00, 1);
    send(10'h00F, 1, 8'hEF, 2'b00, 1);
    send(10'h2AB, 1, 8'h00, 2'b11, 0);
    send(10'h0FF, 1, 8'hFF, 2'b11, 1);
    idle(1);
    send(10'h154, 1, 8'h00, 2'b10, 0);
    send(10'h1AA, 1, 8'hFE, 2'b10, 1);
    idle(3);

    // Reset while locked with symbols in flight.
    send(10'h1FF, 0, 8'h00, 2'b00, 0);
    send(10'h0FF, 0, 8'h00, 2'b00, 0);
    check("pre_reset_locked", locked_out, 1);
    rst_in = 1'b1;
    sbq.delete();
    #1;
    check_all_zero("midreset");
    idle(2);
    rst_in = 1'b0;
    idle(3);

    // A data symbol inside the token run restarts the count.
    for (int i = 0; i < 10; i++) send(10'h354, 1, 8'h00, 2'b00, 0);
    send(10'h1FF, 1, 8'h01, 2'b00, 0);
    check("locked_after_break", locked_out, 0);
    for (int i = 0; i < 16; i++) begin
      send(10'h354, 1, 8'h00, 2'b00, 0);
      if (i == 14) check("verify_locked_before_16th", locked_out, 0);
    end
    check("verify_locked_after_16th", locked_out, 1);

    // Lock loss after a full timeout of data without blanking.
    slips_before = n_slip;
    send(10'h0AB, 1, 8'h00, 2'b01, 0);
    for (int i = 0; i < 4096; i++) begin
      send(10'h1FF, 1, 8'h01, 2'b01, 1);
      if (i == 4094) check("still_locked_4095", locked_out, 1);
    end
    check("lock_lost_4096", locked_out, 0);
    send(10'h1FF, 1, 8'h01, 2'b01, 0);
    idle(3);
    check("no_bitslip_on_lock_loss", n_slip - slips_before, 0);

    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    idle(2);

    // Stream misaligned by 3 bits; the bench shifts its window on each bitslip.
    slips_before = n_slip;
    off = 3;
    n = 0;
    first_slip = -1;
    second_slip = -1;
    lock_n = -1;
    for (int i = 0; i < 20000 && lock_n < 0; i++) begin
      send(rot(10'h354, off), 0, 8'h00, 2'b00, 0);
      n++;
      if (bitslip_out) begin
        if (first_slip < 0) first_slip = n;
        else if (second_slip < 0) second_slip = n;
        off = (off + 9) % 10;
      end
      if (locked_out) lock_n = n;
    end
    check("first_slip_symbol", first_slip, 4096);
    check("second_slip_symbol", second_slip, 8208);
    check("misalign_lock_symbol", lock_n, 12352);
    check("misalign_slip_count", n_slip - slips_before, 3);
    check("misalign_final_offset", off, 0);

    idle(4);
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
